// File: rtl/contador_cm_pkg.sv
// Shared encodings for the cm-counting control unit: state codes and error codes.
package contador_cm_pkg;

  localparam logic [3:0] ST_INICIAL      = 4'd0;
  localparam logic [3:0] ST_PREPARACAO   = 4'd1;
  localparam logic [3:0] ST_ESPERA_PULSO = 4'd2;
  localparam logic [3:0] ST_MEDIDA       = 4'd3;
  localparam logic [3:0] ST_INCREMENTA   = 4'd4;
  localparam logic [3:0] ST_FINAL        = 4'd5;
  localparam logic [3:0] ST_ERRO         = 4'd6;

  typedef enum logic [3:0] {
    INICIAL      = ST_INICIAL,
    PREPARACAO   = ST_PREPARACAO,
    ESPERA_PULSO = ST_ESPERA_PULSO,
    MEDIDA       = ST_MEDIDA,
    INCREMENTA   = ST_INCREMENTA,
    FINAL        = ST_FINAL,
    ERRO         = ST_ERRO
  } estado_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both edges are delayed
// by two clocks, so pulse width is preserved.
module sincronizador_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/contador_cm_uc.sv
// Control unit for one ultrasonic echo measurement: clears the tick/BCD datapath,
// waits for the echo, converts ticks into BCD increments and reports done or error.
//
// state        | meaning
// INICIAL      | idle, waiting for medir
// PREPARACAO   | clear datapath, timeout counter and error code
// ESPERA_PULSO | waiting for echo rise, timeout running
// MEDIDA       | echo high, tick generator enabled
// INCREMENTA   | one BCD increment for the tick just seen
// FINAL        | pronto pulse, result held in datapath
// ERRO         | erro pulse, codigo_erro tells why
module contador_cm_uc
  import contador_cm_pkg::*;
#(
  parameter int TIMEOUT = 1000000,
  parameter int NT      = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       medir,
  input  logic       pulso,
  input  logic       tick,
  input  logic       fim,
  output logic       zera_tick,
  output logic       conta_tick,
  output logic       zera_bcd,
  output logic       conta_bcd,
  output logic       pronto,
  output logic       erro,
  output logic [1:0] codigo_erro,
  output logic [3:0] db_estado
);

  estado_t       estado;
  estado_t       prox;
  logic          pulso_s;
  logic [NT-1:0] cnt_timeout;
  logic          timeout_hit;

  sincronizador_2ff u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (pulso),
    .q     (pulso_s)
  );

  assign timeout_hit = (cnt_timeout == NT'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INICIAL;
    end else begin
      estado <= prox;
    end
  end

  always_comb begin
    prox       = estado;
    zera_tick  = 1'b0;
    conta_tick = 1'b0;
    zera_bcd   = 1'b0;
    conta_bcd  = 1'b0;
    pronto     = 1'b0;
    erro       = 1'b0;
    case (estado)
      INICIAL: begin
        if (medir) prox = PREPARACAO;
      end
      PREPARACAO: begin
        zera_tick = 1'b1;
        zera_bcd  = 1'b1;
        prox      = ESPERA_PULSO;
      end
      ESPERA_PULSO: begin
        // echo rising in the very last cycle still counts as a valid start
        if (pulso_s)          prox = MEDIDA;
        else if (timeout_hit) prox = ERRO;
      end
      MEDIDA: begin
        conta_tick = 1'b1;
        if (!pulso_s)  prox = FINAL;
        else if (tick) prox = INCREMENTA;
      end
      INCREMENTA: begin
        // keep the tick generator running so its phase is not lost
        conta_tick = 1'b1;
        conta_bcd  = ~fim;
        if (fim)           prox = ERRO;
        else if (!pulso_s) prox = FINAL;
        else               prox = MEDIDA;
      end
      FINAL: begin
        pronto = 1'b1;
        prox   = INICIAL;
      end
      ERRO: begin
        erro = 1'b1;
        prox = INICIAL;
      end
      default: begin
        prox = INICIAL;
      end
    endcase
  end

  // saturating so a stuck state can never wrap back into a false timeout
  always_ff @(posedge clock) begin
    if (reset || estado == PREPARACAO) begin
      cnt_timeout <= '0;
    end else if (estado == ESPERA_PULSO && cnt_timeout != '1) begin
      cnt_timeout <= cnt_timeout + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || estado == PREPARACAO) begin
      codigo_erro <= ERR_NONE;
    end else if (estado == ESPERA_PULSO && !pulso_s && timeout_hit) begin
      codigo_erro <= ERR_TIMEOUT;
    end else if (estado == INCREMENTA && fim) begin
      codigo_erro <= ERR_OVERFLOW;
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_contador_cm_uc.sv
// Scoreboard bench for contador_cm_uc driving a behavioural tick/BCD datapath.
module tb_contador_cm_uc;

  localparam int TIMEOUT = 100;
  localparam int NT      = 7;

  logic       clock = 1'b0;
  logic       reset;
  logic       medir;
  logic       pulso;
  logic       tick;
  logic       fim;
  logic       zera_tick;
  logic       conta_tick;
  logic       zera_bcd;
  logic       conta_bcd;
  logic       pronto;
  logic       erro;
  logic [1:0] codigo_erro;
  logic [3:0] db_estado;

  always #5 clock = ~clock;

  contador_cm_uc #(.TIMEOUT(TIMEOUT), .NT(NT)) dut (
    .clock       (clock),
    .reset       (reset),
    .medir       (medir),
    .pulso       (pulso),
    .tick        (tick),
    .fim         (fim),
    .zera_tick   (zera_tick),
    .conta_tick  (conta_tick),
    .zera_bcd    (zera_bcd),
    .conta_bcd   (conta_bcd),
    .pronto      (pronto),
    .erro        (erro),
    .codigo_erro (codigo_erro),
    .db_estado   (db_estado)
  );

  // datapath model: tick at mid-period of R, BCD counter that wraps if pushed past 999
  int r_div   = 10;
  int tcnt    = 0;
  int bcd_val = 0;

  always @(posedge clock) begin
    if (zera_tick)       tcnt <= 0;
    else if (conta_tick) tcnt <= (tcnt == r_div - 1) ? 0 : tcnt + 1;
    if (zera_bcd)        bcd_val <= 0;
    else if (conta_bcd)  bcd_val <= (bcd_val == 999) ? 0 : bcd_val + 1;
  end

  assign tick = conta_tick && (tcnt == r_div / 2 - 1);
  assign fim  = (bcd_val == 999);

  typedef struct {
    bit         is_err;
    logic [1:0] code;
    int         bcd;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  int n_resp = 0, n_conta_bcd = 0, n_pronto = 0, n_conta_tick = 0, excl_viol = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (conta_bcd)  n_conta_bcd++;
      if (pronto)     n_pronto++;
      if (conta_tick) n_conta_tick++;
      if ((zera_tick || zera_bcd) && (conta_tick || conta_bcd)) excl_viol++;
      if (pronto || erro) begin
        n_resp++;
        chk("sb_resp_expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_kind_erro", int'(erro), int'(e.is_err));
          chk("sb_kind_pronto", int'(pronto), int'(!e.is_err));
          chk("sb_codigo_erro", int'(codigo_erro), int'(e.code));
          chk("sb_bcd_value", bcd_val, e.bcd);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_resp(int n0, int limit, string name);
    int i = 0;
    while (n_resp == n0 && i < limit) begin
      step(1);
      i++;
    end
    step(1);
    chk(name, n_resp - n0, 1);
  endtask

  task automatic measure(int delay, int width, int exp_cnt, bit toggle);
    int n0, c0, k, prep_seen;
    sb.push_back('{1'b0, 2'b00, exp_cnt});
    n0 = n_resp;
    c0 = n_conta_bcd;
    prep_seen = 0;
    medir = 1'b1;
    step(1);
    medir = 1'b0;
    step(delay);
    pulso = 1'b1;
    for (int i = 0; i < width; i++) begin
      if (toggle) medir = (i % 4) < 2;
      step(1);
      if (db_estado == 4'd1) prep_seen++;
    end
    medir = 1'b0;
    pulso = 1'b0;
    k = 0;
    while (!pronto && k < 10) begin
      step(1);
      k++;
    end
    chk("pronto_latency_2_3", int'(k >= 2 && k <= 3), 1);
    wait_resp(n0, 10, "measure_done");
    chk("conta_bcd_pulses", n_conta_bcd - c0, exp_cnt);
    if (toggle) chk("medir_ignored_busy", prep_seen, 0);
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    failures++;
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, ct0, p0, c0, esp, k;
    reset = 1'b1;
    medir = 1'b0;
    pulso = 1'b0;

    // 1. reset with random inputs
    for (int i = 0; i < 2; i++) begin
      medir = 1'($urandom_range(0, 1));
      pulso = 1'($urandom_range(0, 1));
      step(1);
    end
    chk("reset_db_estado", int'(db_estado), 0);
    chk("reset_outputs", int'({zera_tick, conta_tick, zera_bcd, conta_bcd, pronto, erro}), 0);
    chk("reset_codigo", int'(codigo_erro), 0);
    medir = 1'b0;
    pulso = 1'b0;
    reset = 1'b0;
    step(3);
    chk("idle_stays_inicial", int'(db_estado), 0);

    // 2. normal measurement: 50-cycle echo, R=10 -> 5
    measure(5, 50, 5, 1'b0);

    // 3. timeout
    sb.push_back('{1'b1, 2'b01, 0});
    n0  = n_resp;
    ct0 = n_conta_tick;
    medir = 1'b1;
    step(1);
    medir = 1'b0;
    chk("timeout_prep_state", int'(db_estado), 1);
    esp = 0;
    k = 0;
    while (db_estado != 4'd6 && k < 300) begin
      step(1);
      if (db_estado == 4'd2) esp++;
      k++;
    end
    chk("timeout_espera_cycles", esp, TIMEOUT);
    wait_resp(n0, 5, "timeout_done");
    chk("timeout_codigo_held", int'(codigo_erro), 1);
    chk("timeout_no_conta_tick", n_conta_tick - ct0, 0);

    // 6b. back-to-back with medir held: clears previous error code
    sb.push_back('{1'b0, 2'b00, 5});
    sb.push_back('{1'b0, 2'b00, 3});
    n0 = n_resp;
    medir = 1'b1;
    step(6);
    pulso = 1'b1;
    step(50);
    pulso = 1'b0;
    k = 0;
    while (db_estado != 4'd5 && k < 20) begin
      step(1);
      k++;
    end
    chk("b2b_final", int'(db_estado), 5);
    step(1);
    chk("b2b_inicial", int'(db_estado), 0);
    step(1);
    chk("b2b_preparacao", int'(db_estado), 1);
    medir = 1'b0;
    step(5);
    pulso = 1'b1;
    step(30);
    pulso = 1'b0;
    k = 0;
    while (n_resp - n0 < 2 && k < 20) begin
      step(1);
      k++;
    end
    chk("b2b_two_results", n_resp - n0, 2);
    chk("b2b_codigo_cleared", int'(codigo_erro), 0);

    // 6a. medir toggled during MEDIDA has no effect
    measure(5, 50, 5, 1'b1);

    // 4. overflow with R=4 and echo stuck high
    r_div = 4;
    sb.push_back('{1'b1, 2'b10, 999});
    n0 = n_resp;
    p0 = n_pronto;
    c0 = n_conta_bcd;
    medir = 1'b1;
    step(1);
    medir = 1'b0;
    step(5);
    pulso = 1'b1;
    wait_resp(n0, 6000, "overflow_done");
    pulso = 1'b0;
    chk("overflow_no_pronto", n_pronto - p0, 0);
    chk("overflow_increments", n_conta_bcd - c0, 999);
    chk("overflow_no_wrap", bcd_val, 999);
    step(4);

    // 5. reset in the middle of MEDIDA
    r_div = 10;
    medir = 1'b1;
    step(1);
    medir = 1'b0;
    step(5);
    pulso = 1'b1;
    k = 0;
    while (!(bcd_val == 3 && db_estado == 4'd3) && k < 200) begin
      step(1);
      k++;
    end
    chk("midop_reached_3", bcd_val, 3);
    reset = 1'b1;
    step(1);
    chk("midop_reset_state", int'(db_estado), 0);
    chk("midop_reset_conta_tick", int'(conta_tick), 0);
    reset = 1'b0;
    pulso = 1'b0;
    step(3);
    measure(5, 50, 5, 1'b0);

    chk("sb_drained", sb.size(), 0);
    chk("zera_conta_exclusive", excl_viol, 0);
    summary();
    $finish;
  end

endmodule
